btn_event: RTL and testbench

Per-button event generator downstream of the `debounce` stage. Takes N already-debounced, clean button levels and converts each into single-cycle `press` / `release` pulses. While a button is held, it also produces a long-press auto-repeat pulse train. Its outputs feed the lab's control logic, e.g. step/advance commands for the display and register-file front panel.

---
 rtl/btn_event.sv | 74 +++++++
 tb/tb_btn_event.sv | 114 +++++++++++
 2 files changed

// File: rtl/btn_event.sv
// btn_event: per-button press/release pulses plus long-press auto-repeat for N debounced buttons.
// Every event output comes from a register, two clocks after the button level.
module btn_event #(
   parameter int N        = 5,
   parameter int LONG_CYC = 50_000_000,
   parameter int REP_CYC  = 10_000_000,
   parameter int CW       = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] btn,
   output logic [N-1:0] press,
   output logic [N-1:0] rel,
   output logic [N-1:0] rep,
   output logic [N-1:0] held
);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] HOLD   = 2'd1;
   localparam logic [1:0] REPEAT = 2'd2;
   localparam logic [CW-1:0] LT = CW'(LONG_CYC - 1);
   localparam logic [CW-1:0] RT = CW'(REP_CYC - 1);
   logic [N-1:0] s, p, rise, fall;
   always_ff @(posedge clk) begin
      if (rst) begin
         s <= '0;
         p <= '0;
      end else begin
         s <= btn;
         p <= s;
      end
   end
   assign rise = s & ~p;
   assign fall = ~s & p;
   for (genvar i = 0; i < N; i++) begin : g_btn
      logic [1:0]    st;
      logic [CW-1:0] cnt;
      logic          pr, rl, rp;
      // a falling edge is tested before the terminal count so release wins a tie
      always_ff @(posedge clk) begin
         if (rst) begin
            st  <= IDLE;
            cnt <= '0;
            pr  <= 1'b0;
            rl  <= 1'b0;
            rp  <= 1'b0;
         end else begin
            pr <= 1'b0;
            rl <= 1'b0;
            rp <= 1'b0;
            if (st == IDLE) begin
               if (rise[i]) begin
                  st  <= HOLD;
                  cnt <= '0;
                  pr  <= 1'b1;
               end
            end else if (fall[i]) begin
               st  <= IDLE;
               cnt <= '0;
               rl  <= 1'b1;
            end else if (cnt == ((st == HOLD) ? LT : RT)) begin
               st  <= REPEAT;
               cnt <= '0;
               rp  <= 1'b1;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
      assign press[i] = pr;
      assign rel[i]   = rl;
      assign rep[i]   = rp;
      assign held[i]  = st != IDLE;
   end
endmodule

// File: tb/tb_btn_event.sv
// tb_btn_event: directed checks of btn_event with LONG_CYC=8, REP_CYC=4.
// Events are recorded as per-bit cycle masks and compared against hand-computed masks.
module tb_btn_event;
   localparam int N = 5;
   typedef struct {
      int          b;
      int          len;
      logic [63:0] rep;
   } vec_t;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] btn = '0;
   logic [N-1:0] press, rel, rep, held;
   logic [63:0]  pm[N], rm[N], qm[N], hm[N];
   int           checks = 0;
   int           errors = 0;
   int           xcl;
   vec_t         tv[7];
   always #5 clk = ~clk;
   btn_event #(.N(N), .LONG_CYC(8), .REP_CYC(4), .CW(4)) dut (
      .clk(clk), .rst(rst), .btn(btn),
      .press(press), .rel(rel), .rep(rep), .held(held)
   );
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   // cycle c = outputs after the c-th posedge following the first drive; btn set just after posedge c
   task automatic run(input int w, input int b0, input int s0, input int l0,
                      input int b1, input int s1, input int l1, input int ra);
      logic [N-1:0] m;
      xcl = 0;
      for (int i = 0; i < N; i++) begin
         pm[i] = '0;
         rm[i] = '0;
         qm[i] = '0;
         hm[i] = '0;
      end
      for (int c = 0; c <= w; c++) begin
         @(posedge clk);
         #1;
         m = '0;
         if (c >= s0 && c < s0 + l0) m[b0] = 1'b1;
         if (c >= s1 && c < s1 + l1) m[b1] = 1'b1;
         btn = m;
         rst = (c == ra);
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            if (press[i]) pm[i][c] = 1'b1;
            if (rel[i])   rm[i][c] = 1'b1;
            if (rep[i])   qm[i][c] = 1'b1;
            if (held[i])  hm[i][c] = 1'b1;
            if ($countones({press[i], rel[i], rep[i]}) > 1) xcl++;
         end
      end
      btn = '0;
      rst = 1'b0;
      repeat (6) @(posedge clk);
   endtask
   initial begin
      logic [63:0] q;
      tv[0] = '{0, 5,  64'h0};
      tv[1] = '{2, 30, 64'h0000_0000_4444_4400};
      tv[2] = '{1, 8,  64'h0};
      tv[3] = '{1, 12, 64'h0000_0000_0000_0400};
      tv[4] = '{3, 1,  64'h0};
      tv[5] = '{4, 9,  64'h0000_0000_0000_0400};
      tv[6] = '{0, 13, 64'h0000_0000_0000_4400};
      @(posedge clk);
      repeat (3) begin
         @(negedge clk);
         chk("in_reset", {press, rel, rep, held}, 64'h0);
         @(posedge clk);
      end
      #1 rst = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk("after_reset", {press, rel, rep, held}, 64'h0);
      end
      for (int k = 0; k < 7; k++) begin
         run(tv[k].len + 8, tv[k].b, 0, tv[k].len, tv[k].b, 0, 0, -1);
         chk($sformatf("case%0d_press", k), pm[tv[k].b], 64'd1 << 2);
         chk($sformatf("case%0d_release", k), rm[tv[k].b], 64'd1 << (tv[k].len + 2));
         chk($sformatf("case%0d_rep", k), qm[tv[k].b], tv[k].rep);
         chk($sformatf("case%0d_held", k), hm[tv[k].b], ((64'd1 << tv[k].len) - 1) << 2);
         q = '0;
         for (int i = 0; i < N; i++) if (i != tv[k].b) q |= pm[i] | rm[i] | qm[i] | hm[i];
         chk($sformatf("case%0d_quiet", k), q, 64'h0);
         chk($sformatf("case%0d_exclusive", k), 64'(xcl), 64'h0);
      end
      run(30, 0, 0, 20, 4, 3, 20, -1);
      chk("indep_press0", pm[0], 64'd1 << 2);
      chk("indep_rep0", qm[0], 64'h0000_0000_0004_4400);
      chk("indep_release0", rm[0], 64'd1 << 22);
      chk("indep_held0", hm[0], ((64'd1 << 20) - 1) << 2);
      chk("indep_press4", pm[4], 64'd1 << 5);
      chk("indep_rep4", qm[4], 64'h0000_0000_0022_2000);
      chk("indep_release4", rm[4], 64'd1 << 25);
      chk("indep_held4", hm[4], ((64'd1 << 20) - 1) << 5);
      chk("indep_quiet", pm[1] | pm[2] | pm[3] | qm[1] | qm[2] | qm[3] | hm[1] | hm[2] | hm[3] | rm[1] | rm[2] | rm[3], 64'h0);
      chk("indep_exclusive", 64'(xcl), 64'h0);
      run(40, 3, 0, 100, 3, 0, 0, 12);
      chk("midrst_press", pm[3], (64'd1 << 2) | (64'd1 << 15));
      chk("midrst_rep", qm[3], 64'h0000_0088_8880_0400);
      chk("midrst_release", rm[3], 64'h0);
      chk("midrst_held", hm[3], (((64'd1 << 11) - 1) << 2) | (((64'd1 << 26) - 1) << 15));
      chk("midrst_exclusive", 64'(xcl), 64'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
